// File: rtl/shift_normalizer_if.sv
// Request/result bundle for shift_normalizer.
// The master side issues start/funct/a; the slave side (the normalizer)
// returns busy/done and the normalized result R, shift count N and zero flag.
interface shift_normalizer_if #(
  parameter int WIDTH = 32,
  parameter int NW    = 5
);
  logic             start;
  logic [1:0]       funct;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] R;
  logic [NW-1:0]    N;
  logic             zero;

  modport master (
    output start, funct, a,
    input  busy, done, R, N, zero
  );

  modport slave (
    input  start, funct, a,
    output busy, done, R, N, zero
  );
endinterface

// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative normalizer, the sequential inverse of the Shifter.
// Captures a word on an accepted start, then shifts it one position per cycle
// until the mode's termination test holds, reporting the normalized word R,
// the shift count N and a zero-operand flag.
//   funct 00: left-normalize unsigned  (stop when msb is 1)
//   funct 01: left-normalize signed    (stop when msb differs from msb-1)
//   funct 10: right-strip zeros, logical fill    (stop when lsb is 1)
//   funct 11: right-strip zeros, arithmetic fill (stop when lsb is 1)
// A zero operand or reaching a count of WIDTH-1 also terminates.
// Optional build macro SHIFT_NORMALIZER_FAST_EN: in modes 00/10/11 a nibble of
// zeros on the examined side is skipped in a single cycle (shift by 4).
// Results are the same with or without the macro; only latency changes.
module shift_normalizer #(
  parameter int WIDTH = 32,
  parameter int NW    = 5
) (
  input logic              clk,
  input logic              rst,
  shift_normalizer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [NW-1:0] CNT_CAP  = NW'(WIDTH - 1);
  localparam logic [NW-1:0] FAST_MAX = NW'(WIDTH - 5);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [1:0]       mode_q,  mode_d;
  logic [NW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic [NW-1:0]    n_q,     n_d;
  logic             zero_q,  zero_d;
  logic [2:0]       step_amt;

  // Mode-specific "this word is normalized" test.
  function automatic logic term_hit(input logic [1:0] mode, input logic [WIDTH-1:0] w);
    logic hit;
    case (mode)
      2'b00:   hit = w[WIDTH-1];
      2'b01:   hit = w[WIDTH-1] ^ w[WIDTH-2];
      default: hit = w[0];
    endcase
    return hit;
  endfunction

  // Shift the work word by amt in the mode's direction with the mode's fill.
  // For mode 11 the msb of the work word always equals the captured operand's
  // sign bit (arithmetic shifts replicate it), so >>> fills with that sign.
  function automatic logic [WIDTH-1:0] shift_step(input logic [1:0]       mode,
                                                  input logic [WIDTH-1:0] w,
                                                  input logic [2:0]       amt);
    logic signed [WIDTH-1:0] ws;
    logic        [WIDTH-1:0] res;
    ws = w;
    case (mode)
      2'b00, 2'b01: res = w << amt;
      2'b10:        res = w >> amt;
      default:      res = $unsigned(ws >>> amt);
    endcase
    return res;
  endfunction

`ifdef SHIFT_NORMALIZER_FAST_EN
  // Pick a 4-position jump when the next nibble on the examined side is empty.
  always_comb begin
    logic nib_zero;
    if (mode_q == 2'b00) begin
      nib_zero = (work_q[WIDTH-1 -: 4] == 4'd0);
    end else begin
      nib_zero = (work_q[3:0] == 4'd0);
    end
    if ((mode_q != 2'b01) && nib_zero && (cnt_q <= FAST_MAX)) begin
      step_amt = 3'd4;
    end else begin
      step_amt = 3'd1;
    end
  end
`else
  // Single-bit stepping throughout.
  always_comb begin
    step_amt = 3'd1;
  end
`endif

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    n_d     = n_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          work_d  = bus.a;
          mode_d  = bus.funct;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (work_q == '0) begin
          r_d     = '0;
          n_d     = '0;
          zero_d  = 1'b1;
          state_d = ST_DONE;
        end else if (term_hit(mode_q, work_q) || (cnt_q == CNT_CAP)) begin
          r_d     = work_q;
          n_d     = cnt_q;
          zero_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          work_d = shift_step(mode_q, work_q, step_amt);
          cnt_d  = cnt_q + NW'(step_amt);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and architecturally visible results, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      n_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      n_q     <= n_d;
      zero_q  <= zero_d;
    end
  end

  // Working operand, mode and count; only meaningful while in SHIFT.
  always_ff @(posedge clk) begin
    work_q <= work_d;
    mode_q <= mode_d;
    cnt_q  <= cnt_d;
  end

  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_DONE);
  assign bus.R    = r_q;
  assign bus.N    = n_q;
  assign bus.zero = zero_q;

endmodule
